timebase_gen: RTL
=================

// Module: timebase_gen
// PURPOSE
//   Parametrised crystal timebase for the clock: divides CLK_HZ (default 32.768 kHz) to 1 Hz.
//   Outputs: 50% 1 Hz square wave, 1-cycle second/minute strobes, a FAST_HZ square wave for
//   colon blinking, and a 0..59 seconds count. Supports sync restart and optional ppm trim.
//   Sits between the oscillator input and the time-of-day counters/display logic.
// PARAMETERS
//   CLK_HZ    32768  input clock frequency; one second = CLK_HZ cycles (untrimmed)
//   FAST_HZ   16     fst frequency; CLK_HZ must be divisible by 2*FAST_HZ
//   TRIM_W    8      width of signed trim value; must satisfy 2^(TRIM_W-1) < CLK_HZ/2
//   CNT_W     $clog2(CLK_HZ)+1 (localparam)  divider width, headroom for positive trim
// PORTS
//   clk        in   1       timebase clock (CLK_HZ)
//   rstn       in   1       asynchronous active-low reset
//   sync       in   1       synchronous restart of the second (set button / external PPS)
//   trim_load  in   1       1-cycle strobe: capture trim_val into trim_reg
//   trim_val   in   TRIM_W  signed cycles added to the trimmed second
//   pps        out  1       1 Hz square wave, high in second half of each second
//   pps_tick   out  1       1-cycle strobe at each second boundary
//   fst        out  1       FAST_HZ square wave, phase-locked to the second
//   sec        out  6       seconds 0..59
//   min_tick   out  1       1-cycle strobe when sec wraps 59->0 (coincident with pps_tick)
// BEHAVIOUR
//   - Reset (rstn=0, async): count, fast counter, sec, trim_reg, pps, pps_tick, fst,
//     min_tick all 0. Release starts counting on the first clk edge; no tick from reset.
//   - Terminal count TC = CLK_HZ-1, except when sec==59: TC = CLK_HZ-1+trim_reg (sign-extended).
//   - Each clk: if count >= TC then count<=0 (wrap) else count<=count+1. >= (not ==) so a
//     trim change that puts TC below count wraps on the next edge, never runs to 2^CNT_W.
//   - Wrap: pps_tick=1 for exactly the following cycle (registered, coincident with count==0);
//     sec<=sec+1, 59->0 with min_tick=1 same cycle as pps_tick.
//   - pps registered: 1 when count >= CLK_HZ/2, else 0; threshold unaffected by trim.
//   - fst: half-period H=CLK_HZ/(2*FAST_HZ) cycles; toggles every H cycles; fast counter and
//     fst forced to 0 at every wrap, so a trimmed second may yield one short/long last phase.
//   - sync=1: count<=0, fast counter<=0, fst<=0, pps<=0, sec<=0; no pps_tick/min_tick that
//     cycle. sync coincident with a wrap: sync wins, no strobes. sync held high: held at 0.
//   - trim_load: trim_reg<=trim_val next edge; effective immediately (TC combinational),
//     incl. mid-second 59. trim_load and sync together: both take effect.
//   - All outputs registered; no combinational input-to-output paths.
// CONFIGURATION
//   TIMEBASE_TRIM_EN defined: trim_reg and trimmed TC as above.
//   Not defined: trim_reg absent, TC = CLK_HZ-1 always; trim_load/trim_val ignored
//   (left unconnected internally); all other behaviour identical.
// TESTING (CLK_HZ=16, FAST_HZ=2, TRIM_W=3 unless noted; TIMEBASE_TRIM_EN defined)
//   1 Reset: rstn low mid-count -> all outputs 0 immediately, async; release -> first
//     pps_tick after 16 edges, pps high cycles 8..15 of each second.
//   2 Free run 60 s: pps_tick every 16 cycles, fst toggles every 4 cycles, sec 0..59,
//     min_tick only with sec 59->0 tick; CLK_HZ=32768 default: tick every 32768 cycles.
//   3 trim_val=+3 loaded: second 59 lasts 19 cycles, others 16; trim_val=-3: second 59 lasts 13.
//   4 Load trim -3 when count=14 in second 59 -> wrap on next edge, pps_tick follows, sec=0.
//   5 sync at count=10, sec=30 -> count=0, sec=0, no tick; sync on wrap cycle -> no strobes.
//   6 Build without TIMEBASE_TRIM_EN, trim_val=+3 loaded -> every second exactly 16 cycles.

Source files
------------

// File: rtl/timebase_gen.sv
// Divides CLK_HZ to 1 Hz: pps square wave, second/minute strobes, FAST_HZ blink wave, 0..59 seconds.
// Latency: all outputs registered, aligned with the internal count (pps_tick high while count==0).
// Backpressure: none, free-running; sync restarts the second. Optional ppm trim under TIMEBASE_TRIM_EN.
module timebase_gen #(
    parameter int CLK_HZ  = 32768,
    parameter int FAST_HZ = 16,
    parameter int TRIM_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              sync,
    input  logic              trim_load,
    input  logic [TRIM_W-1:0] trim_val,
    output logic              pps,
    output logic              pps_tick,
    output logic              fst,
    output logic [5:0]        sec,
    output logic              min_tick
);

    localparam int CNT_W  = $clog2(CLK_HZ) + 1;
    localparam int HALF   = CLK_HZ / (2 * FAST_HZ);
    localparam int FAST_W = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [CNT_W-1:0]  TC_BASE   = CNT_W'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0]  PPS_ON    = CNT_W'(CLK_HZ / 2);
    localparam logic [FAST_W-1:0] FAST_LAST = FAST_W'(HALF - 1);
    localparam logic [5:0]        SEC_LAST  = 6'd59;

    logic [CNT_W-1:0]  count_q, count_d;
    logic [FAST_W-1:0] fast_q, fast_d;
    logic [5:0]        sec_q, sec_d;
    logic              pps_q, pps_d;
    logic              tick_q, tick_d;
    logic              fst_q, fst_d;
    logic              min_q, min_d;
    logic [CNT_W-1:0]  tc;
    logic              wrap;

`ifdef TIMEBASE_TRIM_EN
    logic [TRIM_W-1:0] trim_q, trim_d;

    always_comb begin
        trim_d = trim_load ? trim_val : trim_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trim_q <= '0;
        end else begin
            trim_q <= trim_d;
        end
    end

    // Trim only stretches/shrinks the last second of the minute; combinational so a load acts at once.
    always_comb begin
        tc = TC_BASE;
        if (sec_q == SEC_LAST) begin
            tc = TC_BASE + CNT_W'($signed(trim_q));
        end
    end
`else
    logic unused_trim;
    assign unused_trim = ^{trim_load, trim_val};

    always_comb begin
        tc = TC_BASE;
    end
`endif

    // >= rather than == so a trim that drops TC below the current count still wraps next edge.
    assign wrap = (count_q >= tc);

    always_comb begin
        count_d = count_q + CNT_W'(1);
        fast_d  = fast_q + FAST_W'(1);
        fst_d   = fst_q;
        sec_d   = sec_q;
        tick_d  = 1'b0;
        min_d   = 1'b0;
        if (sync) begin
            count_d = '0;
            fast_d  = '0;
            fst_d   = 1'b0;
            sec_d   = '0;
        end else if (wrap) begin
            count_d = '0;
            fast_d  = '0;
            fst_d   = 1'b0;
            tick_d  = 1'b1;
            if (sec_q == SEC_LAST) begin
                sec_d = '0;
                min_d = 1'b1;
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else if (fast_q == FAST_LAST) begin
            fast_d = '0;
            fst_d  = ~fst_q;
        end
        pps_d = (count_d >= PPS_ON);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
            fast_q  <= '0;
            sec_q   <= '0;
            pps_q   <= 1'b0;
            tick_q  <= 1'b0;
            fst_q   <= 1'b0;
            min_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            fast_q  <= fast_d;
            sec_q   <= sec_d;
            pps_q   <= pps_d;
            tick_q  <= tick_d;
            fst_q   <= fst_d;
            min_q   <= min_d;
        end
    end

    assign pps      = pps_q;
    assign pps_tick = tick_q;
    assign fst      = fst_q;
    assign sec      = sec_q;
    assign min_tick = min_q;

endmodule
